line_cache_ctrl: RTL and testbench

//  Direct-mapped read-cache controller; the initiator for the single-port line RAM (one RAM word = tag + 128b line).

---
 rtl/line_cache_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_line_cache_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_cache_ctrl.sv
// Direct-mapped read-cache controller for a single-port line RAM.
// One RAM word holds {tag, w3, w2, w1, w0}; valid bits live in flops so a
// reset empties the cache whatever the RAM still contains. Misses burst a
// 4-word line from the memory arbiter, write it to the RAM and return the
// requested word.
//
// Handshakes: i_req is held high with a stable i_addr until o_ack, which is a
// single-cycle pulse qualifying o_rdata; o_mem_req stays high until the fourth
// i_mem_valid strobe has been taken, one strobe per cycle at most, w0 first.
module line_cache_ctrl #(
    parameter int ADDR_WIDTH  = 26,
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 4,
    parameter int RAM_WIDTH   = TAG_WIDTH + 128
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   o_ack,
    output logic [31:0]            o_rdata,
    input  logic                   i_inv,
    input  logic [ADDR_WIDTH-1:0]  i_inv_addr,
    output logic                   o_mem_req,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_valid,
    input  logic [31:0]            i_mem_data,
    output logic [INDEX_WIDTH-1:0] o_ram_address,
    output logic [RAM_WIDTH-1:0]   o_ram_write_data,
    output logic                   o_ram_write_enable,
    input  logic [RAM_WIDTH-1:0]   i_ram_read_data,
    output logic [1:0]             o_dbg_state
);

    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        valid_d;
    logic [1:0]              cnt_q;
    logic [3:0][31:0]        line_q;
    logic                    inv_pend_q;
    logic [31:0]             rdata_q;
    logic                    mem_req_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    wr_en_q;
    logic [RAM_WIDTH-1:0]    wr_data_q;

    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [INDEX_WIDTH-1:0]  lat_idx;
    logic [INDEX_WIDTH-1:0]  inv_idx;
    logic [TAG_WIDTH-1:0]    lat_tag;
    logic [TAG_WIDTH-1:0]    ram_tag;
    logic [1:0]              lat_off;
    logic [3:0][31:0]        ram_line;
    logic                    inv_hits_lat;
    logic                    hit_d;
    logic                    lookup_ack_d;
    logic                    write_ack_d;
    logic                    unused_bits;

    assign req_idx  = i_addr[INDEX_WIDTH+3:4];
    assign lat_idx  = addr_q[INDEX_WIDTH+3:4];
    assign inv_idx  = i_inv_addr[INDEX_WIDTH+3:4];
    assign lat_tag  = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign lat_off  = addr_q[3:2];
    assign ram_tag  = i_ram_read_data[RAM_WIDTH-1 -: TAG_WIDTH];
    assign ram_line = i_ram_read_data[127:0];

    // Byte-offset bits and the invalidate tag/offset never affect behaviour.
    assign unused_bits = ^{i_addr[1:0], addr_q[1:0], i_inv_addr[ADDR_WIDTH-1:INDEX_WIDTH+4],
                           i_inv_addr[3:0]};

    // A snoop in the lookup cycle for the same line must not be answered from
    // the stale RAM copy, so it forces a miss.
    assign inv_hits_lat = i_inv && (inv_idx == lat_idx);
    assign hit_d        = valid_q[lat_idx] && (ram_tag == lat_tag) && !inv_hits_lat;
    assign lookup_ack_d = (state_q == S_LOOKUP) && hit_d;
    assign write_ack_d  = (state_q == S_WRITE) && i_req;

    // o_ack is decoded from the state rather than registered: a registered
    // pulse would land in IDLE while i_req is still high and re-accept the
    // same request. o_rdata holds the last returned word between acks.
    assign o_ack   = lookup_ack_d || write_ack_d;
    assign o_rdata = lookup_ack_d ? ram_line[lat_off] :
                     write_ack_d  ? line_q[lat_off]   : rdata_q;

    // The RAM must see the incoming index on the accepting edge.
    assign o_ram_address      = (state_q == S_IDLE) ? req_idx : lat_idx;
    assign o_mem_req          = mem_req_q;
    assign o_mem_addr         = mem_addr_q;
    assign o_ram_write_enable = wr_en_q;
    assign o_ram_write_data   = wr_data_q;
    assign o_dbg_state        = state_q;

    // Valid-bit update: a completed fill sets its line, an invalidate clears
    // its line afterwards so it wins when both hit the same index.
    always_comb begin
        valid_d = valid_q;
        if ((state_q == S_WRITE) && !inv_pend_q) begin
            valid_d[lat_idx] = 1'b1;
        end
        if (i_inv) begin
            valid_d[inv_idx] = 1'b0;
        end
    end

    // Controller FSM with its registered outputs, fill buffer and valid bits.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            cnt_q      <= 2'd0;
            line_q     <= '0;
            inv_pend_q <= 1'b0;
            rdata_q    <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            case (state_q)
                S_IDLE: begin
                    inv_pend_q <= 1'b0;
                    if (i_req) begin
                        addr_q  <= i_addr;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_d) begin
                        rdata_q <= ram_line[lat_off];
                        state_q <= S_IDLE;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {addr_q[ADDR_WIDTH-1:4], 4'b0000};
                        cnt_q      <= 2'd0;
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (inv_hits_lat) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (i_mem_valid) begin
                        line_q[cnt_q] <= i_mem_data;
                        cnt_q         <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            mem_req_q <= 1'b0;
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {lat_tag, i_mem_data, line_q[2], line_q[1], line_q[0]};
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    wr_en_q    <= 1'b0;
                    inv_pend_q <= 1'b0;
                    if (i_req) begin
                        rdata_q <= line_q[lat_off];
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_cache_ctrl.sv
// Directed bench for line_cache_ctrl: behavioural line RAM with a registered
// read port, a memory responder inside the read task, and immediate-assertion
// checks against hand-computed values.
module tb_line_cache_ctrl;

    localparam int AW = 26;
    localparam int IW = 7;
    localparam int TW = AW - IW - 4;
    localparam int RW = TW + 128;

    logic          i_clk;
    logic          i_reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          o_ack;
    logic [31:0]   o_rdata;
    logic          i_inv;
    logic [AW-1:0] i_inv_addr;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_valid;
    logic [31:0]   i_mem_data;
    logic [IW-1:0] o_ram_address;
    logic [RW-1:0] o_ram_write_data;
    logic          o_ram_write_enable;
    logic [RW-1:0] ram_rd;
    logic [1:0]    o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    line_cache_ctrl #(
        .ADDR_WIDTH (AW),
        .INDEX_WIDTH(IW)
    ) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_req             (i_req),
        .i_addr            (i_addr),
        .o_ack             (o_ack),
        .o_rdata           (o_rdata),
        .i_inv             (i_inv),
        .i_inv_addr        (i_inv_addr),
        .o_mem_req         (o_mem_req),
        .o_mem_addr        (o_mem_addr),
        .i_mem_valid       (i_mem_valid),
        .i_mem_data        (i_mem_data),
        .o_ram_address     (o_ram_address),
        .o_ram_write_data  (o_ram_write_data),
        .o_ram_write_enable(o_ram_write_enable),
        .i_ram_read_data   (ram_rd),
        .o_dbg_state       (o_dbg_state)
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Single-port line RAM, 1-cycle registered read, read-before-write
    logic [RW-1:0] ram [0:(1<<IW)-1];
    initial begin
        for (int i = 0; i < (1 << IW); i++) ram[i] = '0;
        ram_rd = '0;
    end
    always @(posedge i_clk) begin
        if (o_ram_write_enable) ram[o_ram_address] <= o_ram_write_data;
        ram_rd <= ram[o_ram_address];
    end

    task automatic check(input string name, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One CPU read. Called and returning at a negedge. Serves the fill burst
    // with words base..base+3, optionally pulses i_inv at inv_step and drops
    // i_req at drop_step (0 = never). Miss path: accept, LOOKUP, then the
    // ack is seen 6 steps after the request was raised; a hit is seen at step 1.
    task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [31:0] base,
                           input bit exp_miss, input bit exp_ack, input logic [31:0] exp_rdata,
                           input int inv_step, input logic [AW-1:0] inv_addr, input int drop_step);
        bit            ack_seen = 0;
        bit            miss_seen = 0;
        bit            wr_seen = 0;
        int            ack_step = 0;
        int            wr_step = 0;
        int            fed = 0;
        logic [31:0]   rdata_obs = '0;
        logic [AW-1:0] maddr_obs = '0;
        logic [IW-1:0] widx_obs = '0;
        logic [RW-1:0] wdata_obs = '0;
        logic [RW-1:0] exp_wd;
        exp_wd = {addr[AW-1:IW+4], base + 32'd3, base + 32'd2, base + 32'd1, base};
        i_req  = 1'b1;
        i_addr = addr;
        for (int step = 1; step <= 30; step++) begin
            @(negedge i_clk);
            if (o_mem_req && !miss_seen) begin
                miss_seen = 1;
                maddr_obs = o_mem_addr;
            end
            if (o_ram_write_enable) begin
                wr_seen   = 1;
                wr_step   = step;
                widx_obs  = o_ram_address;
                wdata_obs = o_ram_write_data;
            end
            i_inv      = (step == inv_step);
            i_inv_addr = inv_addr;
            if (step == drop_step) i_req = 1'b0;
            if (o_mem_req && fed < 4) begin
                i_mem_valid = 1'b1;
                i_mem_data  = base + 32'(fed);
                fed++;
            end else begin
                i_mem_valid = 1'b0;
            end
            #1;
            if (o_ack) begin
                ack_seen  = 1;
                ack_step  = step;
                rdata_obs = o_rdata;
                break;
            end
            if (!i_req && wr_seen && step > wr_step) break;
        end
        i_req       = 1'b0;
        i_inv       = 1'b0;
        i_mem_valid = 1'b0;
        check({name, "_ack"}, 160'(ack_seen), 160'(exp_ack));
        check({name, "_miss"}, 160'(miss_seen), 160'(exp_miss));
        if (exp_ack) begin
            check({name, "_rdata"}, 160'(rdata_obs), 160'(exp_rdata));
            check({name, "_latency"}, 160'(ack_step), exp_miss ? 160'd6 : 160'd1);
        end
        if (exp_miss) begin
            check({name, "_mem_addr"}, 160'(maddr_obs), 160'({addr[AW-1:4], 4'b0000}));
            check({name, "_ram_wr"}, 160'(wr_seen), 160'd1);
            check({name, "_ram_idx"}, 160'(widx_obs), 160'(addr[IW+3:4]));
            check({name, "_ram_data"}, 160'(wdata_obs), 160'(exp_wd));
        end
        @(negedge i_clk);
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_req       = 1'b0;
        i_addr      = '0;
        i_inv       = 1'b0;
        i_inv_addr  = '0;
        i_mem_valid = 1'b0;
        i_mem_data  = '0;

        // Reset values
        repeat (2) @(negedge i_clk);
        #1;
        check("rst_ack", 160'(o_ack), 160'd0);
        check("rst_mem_req", 160'(o_mem_req), 160'd0);
        check("rst_ram_we", 160'(o_ram_write_enable), 160'd0);
        check("rst_rdata", 160'(o_rdata), 160'd0);
        check("rst_mem_addr", 160'(o_mem_addr), 160'd0);
        check("rst_ram_wd", 160'(o_ram_write_data), 160'd0);
        check("rst_state", 160'(o_dbg_state), 160'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // 0x0001230: index 0x23, tag = addr[25:11] = 2, offset 0
        do_read("miss1", 26'h0001230, 32'hA0, 1, 1, 32'hA0, 0, '0, 0);
        // Same line, offset 3 -> hit
        do_read("hit1", 26'h000123C, 32'h0, 0, 1, 32'hA3, 0, '0, 0);
        // Same index, tag 0x1002 -> refill replaces the line
        do_read("alias", 26'h0801230, 32'hB0, 1, 1, 32'hB0, 0, '0, 0);
        do_read("remiss", 26'h0001230, 32'hC0, 1, 1, 32'hC0, 0, '0, 0);
        do_read("hit2", 26'h0001234, 32'h0, 0, 1, 32'hC1, 0, '0, 0);

        // Snoop to the same line during LOOKUP forces a miss
        do_read("inv_lookup", 26'h0001230, 32'hD0, 1, 1, 32'hD0, 1, 26'h0001234, 0);
        do_read("hit3", 26'h0001238, 32'h0, 0, 1, 32'hD2, 0, '0, 0);

        // Snoop to the fill index during FILL: line filled but left invalid
        do_read("inv_fill", 26'h0000040, 32'hE0, 1, 1, 32'hE0, 3, 26'h0000048, 0);
        do_read("after_inv", 26'h0000040, 32'hF0, 1, 1, 32'hF0, 0, '0, 0);
        do_read("hit4", 26'h0000040, 32'h0, 0, 1, 32'hF0, 0, '0, 0);

        // Reset after the second fill word, with residual strobes around it
        i_req  = 1'b1;
        i_addr = 26'h0000100;
        for (int step = 1; step <= 3; step++) begin
            @(negedge i_clk);
            if (step >= 2) begin
                check("abort_mem_req", 160'(o_mem_req), 160'd1);
                i_mem_valid = 1'b1;
                i_mem_data  = 32'h5000 + 32'(step);
            end
        end
        @(negedge i_clk);
        i_reset_n   = 1'b0;
        i_req       = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_data  = 32'hDEAD;
        #1;
        check("abort_rst_mem_req", 160'(o_mem_req), 160'd0);
        check("abort_rst_ack", 160'(o_ack), 160'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        #1;
        check("abort_idle_ack", 160'(o_ack), 160'd0);
        check("abort_idle_state", 160'(o_dbg_state), 160'd0);
        i_mem_valid = 1'b0;
        @(negedge i_clk);
        do_read("refill", 26'h0000104, 32'h60, 1, 1, 32'h61, 0, '0, 0);
        // Reset emptied every line, including one that was valid before
        do_read("post_rst", 26'h000123C, 32'h70, 1, 1, 32'h73, 0, '0, 0);

        // Drop i_req during FILL: RAM still written, no ack, then it hits
        do_read("drop", 26'h0000200, 32'h80, 1, 0, 32'h0, 0, '0, 3);
        do_read("hit5", 26'h0000208, 32'h0, 0, 1, 32'h82, 0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
